div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and a 64-bit result.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port `start_i`, input, 1 bit: a divide instruction is present in the execute stage; held high while stalled.
REQ-005 The block SHALL have port `signed_i`, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU; sampled at accept.
REQ-006 The block SHALL have port `a_i`, input, 32 bits: dividend; sampled at accept.
REQ-007 The block SHALL have port `b_i`, input, 32 bits: divisor; sampled at accept.
REQ-008 The block SHALL have port `annul_i`, input, 1 bit: execute-stage flush; cancels any operation in progress.
REQ-009 The block SHALL have port `result_o`, output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-010 The block SHALL have port `ready_o`, output, 1 bit: one-cycle pulse marking `result_o` valid; registered, not combinational.
REQ-011 The block SHALL have port `stall_o`, output, 1 bit: request to hazard logic to freeze F/D/E and bubble M.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, BUSY, DZERO, DONE.
REQ-013 Accept SHALL occur in IDLE when `start_i`=1 and `annul_i`=0; the block latches `a_i`, `b_i` and `signed_i` at that edge.
REQ-014 On accept, `b_i`=0 SHALL go to DZERO; otherwise the block goes to BUSY with the 6-bit iteration counter at 0.
REQ-015 BUSY SHALL run one restoring radix-2 step per cycle on absolute operand values, using a 64-bit partial remainder/quotient shift register.
REQ-016 BUSY SHALL move to DONE after exactly 32 steps, when the counter reaches 31.
REQ-017 DZERO SHALL last one cycle, then go to DONE.
REQ-018 DONE SHALL last one cycle with `ready_o`=1, then go to IDLE.
REQ-019 Latency: accept at edge t SHALL give `ready_o`=1 in cycle t+33 (normal) or t+2 (divide-by-zero).
REQ-020 Signed quotient SHALL be negated when operand signs differ.
REQ-021 Signed remainder SHALL take the dividend's sign.
REQ-022 Magnitude of 0x80000000 SHALL be handled as unsigned 0x80000000 with no overflow.
REQ-023 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000, remainder 0.
REQ-024 Divide-by-zero SHALL set `result_o` = 64'h0 with no exception signalled.
REQ-025 `result_o` SHALL update only on the edge entering DONE and SHALL hold until the next DONE.
REQ-026 `stall_o` SHALL be 1 when: state is BUSY or DZERO and `annul_i`=0, or state is IDLE and `start_i`=1 and `annul_i`=0.
REQ-027 `stall_o` SHALL be 0 in DONE, so the pipeline advances in the same cycle HI/LO are written.
REQ-028 `annul_i`=1 in any state SHALL force IDLE at the next edge, with no `ready_o` pulse and `result_o` unchanged.
REQ-029 Annul in DONE SHALL suppress the pulse; `ready_o` is gated by `~annul_i` at the registering edge.
REQ-030 Changes to `start_i` or operand inputs while BUSY or DZERO SHALL be ignored; latched values are used.
REQ-031 `start_i`=1 in the cycle after DONE SHALL be treated as a new operation (back-to-back divides).

Reset
REQ-032 `rst`=1 SHALL asynchronously force: state IDLE, counter 0, `result_o`=0, `ready_o`=0, latched operands 0.
REQ-033 `stall_o` SHALL be 0 while `rst`=1.
REQ-034 Reset mid-BUSY SHALL abandon the operation with no `ready_o` pulse after release.

Verification
REQ-035 Unsigned: 100 / 7 accepted at t -> `ready_o` only at t+33; `result_o`={32'd2, 32'd14}; `stall_o` high t..t+32, low at t+33.
REQ-036 Signed: -7 / 2 -> `result_o`={32'hFFFFFFFF, 32'hFFFFFFFD}; 7 / -2 -> {32'h00000001, 32'hFFFFFFFD}; 0x80000000 / 0xFFFFFFFF -> {0, 32'h80000000}.
REQ-037 Divide-by-zero: a=5, b=0 -> `ready_o` at t+2; `result_o`=64'h0; `stall_o` low at t+2.
REQ-038 Annul at t+10 -> IDLE at t+11; `stall_o` low from t+10; no `ready_o`; previous `result_o` retained.
REQ-039 Async `rst` pulsed at t+15 mid-divide -> all outputs 0 immediately; a fresh 0xFFFFFFFF / 0x10 unsigned afterwards -> {32'hF, 32'h0FFFFFFF} after 33 cycles.
REQ-040 Back-to-back: two divides with `start_i` held continuously -> two `ready_o` pulses exactly 34 cycles apart, each result correct.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the execute-stage pipeline (master) and
// the iterative divider (slave).
interface div_unit_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  modport master (
    output start_i, signed_i, a_i, b_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider, one restoring radix-2 step per cycle.
// Result is {remainder, quotient}, written to HI/LO on the single DONE cycle.
module div_unit (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DZERO, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  cnt;
  logic [63:0] rq;
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] result;
  logic        ready;
  logic        stall;
  logic        accept;

  logic [32:0] top;
  logic [32:0] diff;
  logic [63:0] rq_step;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign accept = bus.start_i && !bus.annul_i;

  // The shifted partial remainder needs 33 bits: it can reach 2*divisor-1.
  always_comb begin
    top     = rq[63:31];
    diff    = top - {1'b0, divisor};
    rq_step = diff[32] ? {rq[62:0], 1'b0} : {diff[31:0], rq[30:0], 1'b1};
    q_fin   = apply_sign(rq_step[31:0], neg_q);
    r_fin   = apply_sign(rq_step[63:32], neg_r);
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (bus.b_i == 32'd0) ? DZERO : BUSY;
          stall      = 1'b1;
        end
      end
      BUSY: begin
        stall = !bus.annul_i;
        if (bus.annul_i)        state_next = IDLE;
        else if (cnt == 6'd31)  state_next = DONE;
      end
      DZERO: begin
        stall      = !bus.annul_i;
        state_next = bus.annul_i ? IDLE : DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      rq      <= 64'd0;
      divisor <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= 64'd0;
      ready   <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == DONE) && !bus.annul_i;
      case (state)
        IDLE: begin
          if (accept) begin
            rq      <= {32'd0, magnitude(bus.a_i, bus.signed_i)};
            divisor <= magnitude(bus.b_i, bus.signed_i);
            neg_q   <= bus.signed_i && (bus.a_i[31] ^ bus.b_i[31]);
            neg_r   <= bus.signed_i && bus.a_i[31];
            cnt     <= 6'd0;
          end
        end
        BUSY: begin
          rq  <= rq_step;
          cnt <= cnt + 6'd1;
          if (state_next == DONE) result <= {r_fin, q_fin};
        end
        DZERO: begin
          if (state_next == DONE) result <= 64'd0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.stall_o  = stall;

endmodule
